// File: rtl/uart_frame_loader.sv
// UART receiver and A5 5A framed image loader.
// Writes one grayscale frame into BRAM and flags it once the checksum matches.
module uart_frame_loader #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int SRC_W        = 320,
  parameter int SRC_H        = 240,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        CLK100MHZ,
  input  logic        reset_async,
  input  logic        UART_RXD,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_ready,
  output logic        loading,
  output logic [2:0]  err_sticky
);

  localparam int CPB        = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = CPB / 2;
  localparam int CW         = $clog2(CPB + 1);
  localparam int FRAME_SIZE = SRC_W * SRC_H;
  localparam int TW         = TIMEOUT_BITS;

  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [16:0]   LAST     = 17'(FRAME_SIZE - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    HUNT0, HUNT1, PAYLOAD, CHECK
  } ld_state_t;

  logic            rx_s1, rx_s2, rx_prev;
  rx_state_t       rx_st, rx_st_d;
  logic [CW-1:0]   clk_cnt, clk_cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            rx_valid, rx_ferr;

  ld_state_t       st, st_d;
  logic [16:0]     cnt, cnt_d;
  logic [7:0]      xacc, xacc_d;
  logic [TW-1:0]   to_cnt, to_cnt_d;
  logic            active, timeout;
  logic            wr_en_d, fr_d, ld_d;
  logic [16:0]     wr_addr_d;
  logic [7:0]      wr_data_d;
  logic [2:0]      err_d;

  // Two-flop synchronizer plus one stage of history for start-edge detect
  always_ff @(posedge CLK100MHZ or posedge reset_async) begin
    if (reset_async) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= UART_RXD;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver state register
  always_ff @(posedge CLK100MHZ or posedge reset_async) begin
    if (reset_async) begin
      rx_st   <= RX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_st   <= rx_st_d;
      clk_cnt <= clk_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
    end
  end

  // Receiver bit timing: mid-bit sampling, false-start and framing checks
  always_comb begin
    rx_st_d   = rx_st;
    clk_cnt_d = clk_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    rx_valid  = 1'b0;
    rx_ferr   = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_st_d   = RX_START;
          clk_cnt_d = '0;
        end
      end
      RX_START: begin
        if (clk_cnt == HALF_END) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          rx_st_d   = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt + C_ONE;
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s2, shift[7:1]};
          if (bit_idx == 3'd7) rx_st_d = RX_STOP;
          else bit_idx_d = bit_idx + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt + C_ONE;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_d = '0;
          rx_st_d   = RX_IDLE;
          if (rx_s2) rx_valid = 1'b1;
          else rx_ferr = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt + C_ONE;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  assign active  = (st == PAYLOAD) || (st == CHECK);
  assign timeout = active && !rx_valid && (to_cnt == '1);

  // Loader state and output registers
  always_ff @(posedge CLK100MHZ or posedge reset_async) begin
    if (reset_async) begin
      st          <= HUNT0;
      cnt         <= '0;
      xacc        <= '0;
      to_cnt      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_ready <= 1'b0;
      loading     <= 1'b0;
      err_sticky  <= '0;
    end else begin
      st          <= st_d;
      cnt         <= cnt_d;
      xacc        <= xacc_d;
      to_cnt      <= to_cnt_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      frame_ready <= fr_d;
      loading     <= ld_d;
      err_sticky  <= err_d;
    end
  end

  // Header hunt, payload write-through, checksum and inter-byte timeout
  always_comb begin
    st_d      = st;
    cnt_d     = cnt;
    xacc_d    = xacc;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    fr_d      = frame_ready;
    ld_d      = loading;
    err_d     = err_sticky | {2'b00, rx_ferr};
    to_cnt_d  = (rx_valid || !active) ? '0 : to_cnt + T_ONE;
    if (timeout) begin
      err_d[2] = 1'b1;
      ld_d     = 1'b0;
      st_d     = HUNT0;
    end else if (rx_valid) begin
      unique case (st)
        HUNT0: begin
          if (shift == 8'hA5) st_d = HUNT1;
        end
        HUNT1: begin
          unique case (1'b1)
            (shift == 8'h5A): begin
              st_d   = PAYLOAD;
              cnt_d  = '0;
              xacc_d = '0;
              ld_d   = 1'b1;
            end
            (shift == 8'hA5): st_d = HUNT1;
            default:          st_d = HUNT0;
          endcase
        end
        PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt;
          wr_data_d = shift;
          xacc_d    = xacc ^ shift;
          fr_d      = 1'b0;
          if (cnt == LAST) st_d = CHECK;
          else cnt_d = cnt + 17'd1;
        end
        CHECK: begin
          if (shift == xacc) fr_d = 1'b1;
          else err_d[1] = 1'b1;
          ld_d = 1'b0;
          st_d = HUNT0;
        end
        default: st_d = HUNT0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader with a scaled-down frame and bit period.
// Expected writes are queued per packet and checked on every write strobe.
module tb_uart_frame_loader;

  localparam int CPB  = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int N    = W * H;
  localparam int TOB  = 9;

  logic        CLK100MHZ = 1'b0;
  logic        reset_async;
  logic        UART_RXD;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_ready;
  logic        loading;
  logic [2:0]  err_sticky;

  int tests = 0;
  int fails = 0;
  int nwrites = 0;
  int last_addr = -1;
  logic prev_we = 1'b0;
  logic [24:0] exp_q[$];

  uart_frame_loader #(
    .CLK_FREQ(CPB * 100),
    .BAUD_RATE(100),
    .SRC_W(W),
    .SRC_H(H),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset_async(reset_async),
    .UART_RXD(UART_RXD),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_ready(frame_ready),
    .loading(loading),
    .err_sticky(err_sticky)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pdata(input int pat, input int i);
    logic [7:0] a;
    a = 8'(i);
    case (pat)
      0:       return a;
      1:       return 8'(i * 37 + 5);
      default: return 8'hFF ^ a;
    endcase
  endfunction

  function automatic logic [7:0] xsum(input int pat);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < N; i++) x ^= pdata(pat, i);
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    UART_RXD = 1'b0;
    repeat (CPB) @(negedge CLK100MHZ);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      repeat (CPB) @(negedge CLK100MHZ);
    end
    UART_RXD = !bad_stop;
    repeat (CPB) @(negedge CLK100MHZ);
    UART_RXD = 1'b1;
    repeat (CPB) @(negedge CLK100MHZ);
  endtask

  task automatic send_range(input int pat, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_q.push_back({17'(i), pdata(pat, i)});
      send_byte(pdata(pat, i), 1'b0);
    end
  endtask

  task automatic send_hdr();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
  endtask

  task automatic glitch();
    UART_RXD = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    UART_RXD = 1'b1;
    repeat (40) @(negedge CLK100MHZ);
  endtask

  // Every write strobe must match the next queued write of the model
  always @(negedge CLK100MHZ) begin
    if (!reset_async) begin
      if (wr_en) begin
        chk("wr_en_b2b", {31'd0, prev_we}, 32'd0);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                   wr_addr, wr_data);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            fails++;
            $display("FAIL write: got %0d/%0h expected %0d/%0h",
                     wr_addr, wr_data, e[24:8], e[7:0]);
          end
        end
        chk("loading_on_write", {31'd0, loading}, 32'd1);
        nwrites++;
        last_addr = int'(wr_addr);
      end
      prev_we = wr_en;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic chk_state(input string tag, input logic fr,
                           input logic ld, input logic [2:0] er,
                           input int nw);
    chk({tag, "_frame_ready"}, {31'd0, frame_ready}, {31'd0, fr});
    chk({tag, "_loading"}, {31'd0, loading}, {31'd0, ld});
    chk({tag, "_err"}, {29'd0, err_sticky}, {29'd0, er});
    chk({tag, "_nwrites"}, nwrites, nw);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
    chk({tag, "_wr_addr"}, {15'd0, wr_addr}, 0);
    chk({tag, "_wr_data"}, {24'd0, wr_data}, 0);
    chk({tag, "_frame_ready"}, {31'd0, frame_ready}, 0);
    chk({tag, "_loading"}, {31'd0, loading}, 0);
    chk({tag, "_err"}, {29'd0, err_sticky}, 0);
  endtask

  initial begin
    UART_RXD    = 1'b1;
    reset_async = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    chk_zero("reset");
    reset_async = 1'b0;
    repeat (5) @(negedge CLK100MHZ);

    chk("xsum_pat0", {24'd0, xsum(0)}, 32'h00);
    chk("pdata_pat1_3", {24'd0, pdata(1, 3)}, 32'h74);

    // good frame, data equals low address byte
    send_hdr();
    send_range(0, 0, N - 1);
    send_byte(xsum(0), 1'b0);
    repeat (4) @(negedge CLK100MHZ);
    chk_state("t1", 1'b1, 1'b0, 3'b000, 16);

    // corrupted checksum; old frame survives the header
    send_hdr();
    chk("t2_hdr_frame_ready", {31'd0, frame_ready}, 1);
    chk("t2_hdr_loading", {31'd0, loading}, 1);
    send_range(1, 0, 0);
    chk("t2_first_write_clears", {31'd0, frame_ready}, 0);
    send_range(1, 1, N - 1);
    send_byte(~xsum(1), 1'b0);
    repeat (4) @(negedge CLK100MHZ);
    chk_state("t2", 1'b0, 1'b0, 3'b010, 32);

    // leading noise, repeated A5 before 5A
    send_byte(8'h13, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_hdr();
    send_range(2, 0, N - 1);
    send_byte(xsum(2), 1'b0);
    repeat (4) @(negedge CLK100MHZ);
    chk_state("t3", 1'b1, 1'b0, 3'b010, 48);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h77, 1'b0);
    chk_state("t3_badhdr", 1'b1, 1'b0, 3'b010, 48);

    // stall mid-payload until timeout, then recover
    send_hdr();
    send_range(1, 0, 9);
    repeat ((1 << TOB) + 10) @(negedge CLK100MHZ);
    chk_state("t4_timeout", 1'b0, 1'b0, 3'b110, 58);
    chk("t4_last_addr", last_addr, 9);
    send_hdr();
    send_range(0, 0, N - 1);
    send_byte(xsum(0), 1'b0);
    repeat (4) @(negedge CLK100MHZ);
    chk_state("t4_recover", 1'b1, 1'b0, 3'b110, 74);

    // framing error and line glitch, idle and mid-payload
    send_byte(8'h33, 1'b1);
    glitch();
    chk_state("t5_idle", 1'b1, 1'b0, 3'b111, 74);
    send_hdr();
    send_range(2, 0, 5);
    glitch();
    send_byte(8'h5A, 1'b1);
    send_range(2, 6, N - 1);
    send_byte(xsum(2), 1'b0);
    repeat (4) @(negedge CLK100MHZ);
    chk_state("t5_frame", 1'b1, 1'b0, 3'b111, 90);

    // reset mid-payload, then a fresh packet
    send_hdr();
    send_range(2, 0, 4);
    repeat (2) @(negedge CLK100MHZ);
    chk_state("t6_pre", 1'b0, 1'b1, 3'b111, 95);
    #2 reset_async = 1'b1;
    #1 chk_zero("t6_async");
    @(negedge CLK100MHZ);
    reset_async = 1'b0;
    repeat (5) @(negedge CLK100MHZ);
    send_hdr();
    send_range(1, 0, N - 1);
    send_byte(xsum(1), 1'b0);
    repeat (4) @(negedge CLK100MHZ);
    chk_state("t6", 1'b1, 1'b0, 3'b000, 111);
    chk("t6_last_addr", last_addr, N - 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
